instr_mem_loader: RTL and testbench

- Writer side of the instruction-memory fill port (write_data / write_address / write_enable) on the single-cycle core.
- Accepts a little-endian byte stream over a valid/ready handshake, assembles 32-bit instructions and issues one write pulse per word.
- Holds the core in reset until the program is fully loaded.
- Sits between the host/debug byte source and the core's fill port.

---
 rtl/loader_pkg.sv | 16 +
 rtl/word_assembler.sv | 32 +++
 rtl/instr_mem_loader.sv | 121 ++++++++++++
 tb/tb_instr_mem_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_WIDTH     = 8;
    localparam int WORD_WIDTH     = BYTES_PER_WORD * BYTE_WIDTH;

    typedef enum logic [2:0] {
        HDR   = 3'd0,
        DATA  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERROR = 3'd4
    } state_t;

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word shift-in register with a 2-bit byte counter.
module word_assembler
    import loader_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  load,
    input  logic [BYTE_WIDTH-1:0] byte_in,
    output logic [WORD_WIDTH-1:0] word,
    output logic                  word_complete
);

    // Only the first three bytes are stored; the fourth is merged combinationally
    // so the full word is usable on the same edge that consumes its last byte.
    logic [WORD_WIDTH-BYTE_WIDTH-1:0] shift_q;
    logic [1:0]                       byte_cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shift_q  <= '0;
            byte_cnt <= '0;
        end else if (load) begin
            shift_q  <= {byte_in, shift_q[WORD_WIDTH-BYTE_WIDTH-1:BYTE_WIDTH]};
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    assign word          = {byte_in, shift_q};
    assign word_complete = load && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a length-prefixed little-endian program into instruction memory and
// holds the core in reset until the whole program has been written.
//
// state | meaning
// HDR   | collecting the 4-byte word count
// DATA  | collecting an instruction word
// WRITE | one-cycle write strobe to the fill port
// DONE  | program loaded, core released
// ERROR | word count too large, core held in reset
module instr_mem_loader
    import loader_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter int               INSTR_MEM_SIZE = 64,
    parameter logic [WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             start,
    output logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] write_address,
    output logic             write_enable,
    output logic             cpu_reset,
    output logic             load_done,
    output logic             load_error
);

    localparam int IDX_W = $clog2(INSTR_MEM_SIZE) + 1;

    state_t                  state;
    logic [WORD_WIDTH-1:0]   word_count;
    logic [IDX_W-1:0]        word_idx;
    logic                    asm_load;
    logic                    asm_clear;
    logic [WORD_WIDTH-1:0]   asm_word;
    logic                    asm_complete;
    logic                    restart;
    logic                    last_word;

    assign in_ready  = !reset && ((state == HDR) || (state == DATA));
    assign asm_load  = in_valid && in_ready;
    assign restart   = start && ((state == DONE) || (state == ERROR));
    assign asm_clear = restart;
    assign last_word = ((WORD_WIDTH'(word_idx) + 32'd1) == word_count);

    word_assembler u_word_assembler (
        .clk           (clk),
        .reset         (reset),
        .clear         (asm_clear),
        .load          (asm_load),
        .byte_in       (in_data),
        .word          (asm_word),
        .word_complete (asm_complete)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= HDR;
            write_enable  <= 1'b0;
            write_data    <= '0;
            write_address <= BASE_ADDR;
            cpu_reset     <= 1'b1;
            load_done     <= 1'b0;
            load_error    <= 1'b0;
            word_count    <= '0;
            word_idx      <= '0;
        end else begin
            write_enable <= 1'b0;
            case (state)
                HDR: begin
                    if (asm_complete) begin
                        word_count <= asm_word;
                        if (asm_word == '0) begin
                            state     <= DONE;
                            cpu_reset <= 1'b0;
                            load_done <= 1'b1;
                        end else if (asm_word > WORD_WIDTH'(INSTR_MEM_SIZE)) begin
                            state      <= ERROR;
                            load_error <= 1'b1;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (asm_complete) begin
                        state         <= WRITE;
                        write_enable  <= 1'b1;
                        write_data    <= WIDTH'(asm_word);
                        write_address <= BASE_ADDR + (WIDTH'(word_idx) << 2);
                    end
                end
                WRITE: begin
                    word_idx <= word_idx + IDX_W'(1);
                    if (last_word) begin
                        state     <= DONE;
                        cpu_reset <= 1'b0;
                        load_done <= 1'b1;
                    end else begin
                        state <= DATA;
                    end
                end
                DONE, ERROR: begin
                    if (restart) begin
                        state      <= HDR;
                        word_count <= '0;
                        word_idx   <= '0;
                        cpu_reset  <= 1'b1;
                        load_done  <= 1'b0;
                        load_error <= 1'b0;
                    end
                end
                default: state <= HDR;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader with default parameters (64 words, base 0).
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        start;
    logic [31:0] write_data;
    logic [31:0] write_address;
    logic        write_enable;
    logic        cpu_reset;
    logic        load_done;
    logic        load_error;

    int checks = 0;
    int errors = 0;
    logic [31:0] wa_q[$];
    logic [31:0] wd_q[$];

    instr_mem_loader dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .start         (start),
        .write_data    (write_data),
        .write_address (write_address),
        .write_enable  (write_enable),
        .cpu_reset     (cpu_reset),
        .load_done     (load_done),
        .load_error    (load_error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (write_enable === 1'b1) begin
            wa_q.push_back(write_address);
            wd_q.push_back(write_data);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the byte is consumed.
    task automatic send(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("send_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int max_gap);
        for (int k = 0; k < 4; k++)
            send(w[8*k +: 8], (max_gap == 0) ? 0 : int'($urandom_range(0, max_gap)));
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        in_data  = 8'h00;
        in_valid = 1'b0;
        start    = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_we", {31'd0, write_enable}, 32'd0);
        chk("rst_wa", write_address, 32'h0);
        chk("rst_wd", write_data, 32'h0);
        chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("rst_done", {31'd0, load_done}, 32'd0);
        chk("rst_error", {31'd0, load_error}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("hdr_in_ready", {31'd0, in_ready}, 32'd1);

        // Two-word load
        send_word(32'h0000_0002, 0);
        send_word(32'h0010_0513, 0);
        chk("t1_we_w0", {31'd0, write_enable}, 32'd1);
        send_word(32'h0020_0593, 0);
        chk("t1_we_w1", {31'd0, write_enable}, 32'd1);
        chk("t1_cpu_reset_in_write", {31'd0, cpu_reset}, 32'd1);
        @(negedge clk);
        chk("t1_done", {31'd0, load_done}, 32'd1);
        chk("t1_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        chk("t1_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t1_we_after", {31'd0, write_enable}, 32'd0);
        chk("t1_nwrites", wa_q.size(), 32'd2);
        if (wa_q.size() == 2) begin
            chk("t1_addr0", wa_q[0], 32'h0);
            chk("t1_data0", wd_q[0], 32'h0010_0513);
            chk("t1_addr1", wa_q[1], 32'h4);
            chk("t1_data1", wd_q[1], 32'h0020_0593);
        end
        wa_q.delete(); wd_q.delete();

        // Zero-length header
        pulse_start();
        chk("t2_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("t2_done_clr", {31'd0, load_done}, 32'd0);
        chk("t2_in_ready", {31'd0, in_ready}, 32'd1);
        send_word(32'h0000_0000, 0);
        chk("t2_done", {31'd0, load_done}, 32'd1);
        chk("t2_cpu_rel", {31'd0, cpu_reset}, 32'd0);
        chk("t2_nwrites", wa_q.size(), 32'd0);
        pulse_start();
        chk("t2_restart_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("t2_restart_in_ready", {31'd0, in_ready}, 32'd1);

        // Oversized header, then recovery
        send_word(32'h0000_0041, 0);
        chk("t3_error", {31'd0, load_error}, 32'd1);
        chk("t3_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t3_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("t3_done", {31'd0, load_done}, 32'd0);
        repeat (3) @(negedge clk);
        chk("t3_nwrites", wa_q.size(), 32'd0);
        chk("t3_error_hold", {31'd0, load_error}, 32'd1);
        pulse_start();
        chk("t3_error_clr", {31'd0, load_error}, 32'd0);
        chk("t3_restart_in_ready", {31'd0, in_ready}, 32'd1);
        send_word(32'h0000_0001, 0);
        send_word(32'hDEAD_BEEF, 0);
        @(negedge clk);
        chk("t3_reload_done", {31'd0, load_done}, 32'd1);
        chk("t3_reload_n", wa_q.size(), 32'd1);
        if (wa_q.size() == 1) begin
            chk("t3_reload_addr", wa_q[0], 32'h0);
            chk("t3_reload_data", wd_q[0], 32'hDEAD_BEEF);
        end
        wa_q.delete(); wd_q.delete();

        // Gaps and a byte offered during the WRITE cycle
        pulse_start();
        send_word(32'h0000_0002, 2);
        send_word(32'h1122_3344, 3);
        in_data  = 8'h5A;
        in_valid = 1'b1;
        chk("t4_write_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t4_write_we", {31'd0, write_enable}, 32'd1);
        send(8'h5A, 0);
        chk("t4_data_state", {31'd0, in_ready}, 32'd1);
        send(8'h5A, 1);
        send(8'hA5, 2);
        send(8'hA5, 1);
        @(negedge clk);
        chk("t4_done", {31'd0, load_done}, 32'd1);
        chk("t4_nwrites", wa_q.size(), 32'd2);
        if (wa_q.size() == 2) begin
            chk("t4_addr0", wa_q[0], 32'h0);
            chk("t4_data0", wd_q[0], 32'h1122_3344);
            chk("t4_addr1", wa_q[1], 32'h4);
            chk("t4_data1", wd_q[1], 32'hA5A5_5A5A);
        end
        wa_q.delete(); wd_q.delete();

        // Reset after six bytes of a three-word load, then a full replay
        pulse_start();
        send_word(32'h0000_0003, 0);
        send(8'h01, 0);
        send(8'h02, 0);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("t5_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_hdr_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t5_cpu_reset", {31'd0, cpu_reset}, 32'd1);
        chk("t5_nwrites_partial", wa_q.size(), 32'd0);
        send_word(32'h0000_0003, 0);
        send_word(32'h0403_0201, 0);
        send_word(32'h0807_0605, 1);
        send_word(32'h0C0B_0A09, 0);
        @(negedge clk);
        chk("t5_done", {31'd0, load_done}, 32'd1);
        chk("t5_nwrites", wa_q.size(), 32'd3);
        if (wa_q.size() == 3) begin
            chk("t5_addr0", wa_q[0], 32'h0);
            chk("t5_data0", wd_q[0], 32'h0403_0201);
            chk("t5_addr1", wa_q[1], 32'h4);
            chk("t5_data1", wd_q[1], 32'h0807_0605);
            chk("t5_addr2", wa_q[2], 32'h8);
            chk("t5_data2", wd_q[2], 32'h0C0B_0A09);
        end
        wa_q.delete(); wd_q.delete();

        // Full-capacity load, then an extra byte that must never be taken
        pulse_start();
        send_word(32'h0000_0040, 0);
        for (int i = 0; i < 64; i++)
            send_word(32'hC0DE_0000 + i, 0);
        @(negedge clk);
        chk("t6_done", {31'd0, load_done}, 32'd1);
        chk("t6_cpu_reset", {31'd0, cpu_reset}, 32'd0);
        chk("t6_nwrites", wa_q.size(), 32'd64);
        if (wa_q.size() == 64) begin
            for (int i = 0; i < 64; i++) begin
                chk("t6_addr", wa_q[i], 32'(4 * i));
                chk("t6_data", wd_q[i], 32'hC0DE_0000 + i);
            end
            chk("t6_last_addr", wa_q[63], 32'hFC);
        end
        in_data  = 8'hFF;
        in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("t6_extra_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        chk("t6_extra_nwrites", wa_q.size(), 32'd64);
        chk("t6_still_done", {31'd0, load_done}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
